// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: funct encodings, ALUOp
// encodings, ALU function codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [3:0] FN_ADD     = 4'd0;
  localparam logic [3:0] FN_SUB     = 4'd1;
  localparam logic [3:0] FN_AND     = 4'd2;
  localparam logic [3:0] FN_OR      = 4'd3;
  localparam logic [3:0] FN_NOR     = 4'd4;
  localparam logic [3:0] FN_SLT     = 4'd5;
  localparam logic [3:0] FN_SLL     = 4'd6;
  localparam logic [3:0] FN_SRL     = 4'd7;
  localparam logic [3:0] FN_SLTU    = 4'd8;
  localparam logic [3:0] FN_MULT    = 4'd9;
  localparam logic [3:0] FN_DIV     = 4'd10;
  localparam logic [3:0] FN_ILLEGAL = 4'hF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational ALUOp/funct decoder: produces the ALU function code plus
// multi-cycle, divide and illegal-funct flags.
module alu_func_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W = 4
) (
  input  logic [5:0]        i_funct,
  input  logic [1:0]        i_alu_op,
  output logic [FUNC_W-1:0] o_func,
  output logic              o_is_multi,
  output logic              o_is_div,
  output logic              o_illegal
);

  logic [3:0] w_code;

  // Decode table; unknown R-type funct codes flag illegal.
  always_comb begin
    w_code     = FN_ADD;
    o_is_multi = 1'b0;
    o_is_div   = 1'b0;
    o_illegal  = 1'b0;
    case (i_alu_op)
      OP_RTYPE: begin
        case (i_funct)
          F_ADD:  w_code = FN_ADD;
          F_SUB:  w_code = FN_SUB;
          F_AND:  w_code = FN_AND;
          F_OR:   w_code = FN_OR;
          F_NOR:  w_code = FN_NOR;
          F_SLT:  w_code = FN_SLT;
          F_SLL:  w_code = FN_SLL;
          F_SRL:  w_code = FN_SRL;
          F_SLTU: w_code = FN_SLTU;
          F_MULT, F_MULTU: begin
            w_code     = FN_MULT;
            o_is_multi = 1'b1;
          end
          F_DIV, F_DIVU: begin
            w_code     = FN_DIV;
            o_is_multi = 1'b1;
            o_is_div   = 1'b1;
          end
          default: begin
            w_code    = FN_ILLEGAL;
            o_illegal = 1'b1;
          end
        endcase
      end
      OP_SUB:  w_code = FN_SUB;
      OP_ADD:  w_code = FN_ADD;
      OP_OR:   w_code = FN_OR;
      default: w_code = FN_ADD;
    endcase

    if (o_illegal) begin
      o_func = '1;
    end else begin
      o_func = FUNC_W'(w_code);
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control with handshake; sequences multi-cycle mult/div by
// pulsing multi_start and reporting completion after a fixed latency.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter  int FUNC_W     = 4,
  parameter  int MUL_CYCLES = 4,
  parameter  int DIV_CYCLES = 8,
  localparam int CNT_W      = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        funct,
  input  logic [1:0]        alu_op,
  output logic [FUNC_W-1:0] func,
  output logic              out_valid,
  output logic              multi_start,
  output logic              busy,
  output logic              illegal
);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [FUNC_W-1:0] r_func, w_func_nxt;
  logic              r_illegal, w_illegal_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_multi_start, w_multi_start_nxt;
  logic              r_busy, w_busy_nxt;

  logic [FUNC_W-1:0] w_dec_func;
  logic              w_dec_multi, w_dec_div, w_dec_illegal;
  logic              w_accept;

  alu_func_decode #(.FUNC_W(FUNC_W)) u_decode (
    .i_funct   (funct),
    .i_alu_op  (alu_op),
    .o_func    (w_dec_func),
    .o_is_multi(w_dec_multi),
    .o_is_div  (w_dec_div),
    .o_illegal (w_dec_illegal)
  );

  // in_ready depends only on state, so there is no in_valid -> in_ready path.
  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and output-register next values.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_func_nxt        = r_func;
    w_illegal_nxt     = r_illegal;
    w_out_valid_nxt   = 1'b0;
    w_multi_start_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_func_nxt    = w_dec_func;
          w_illegal_nxt = w_dec_illegal;
          if (w_dec_multi) begin
            w_multi_start_nxt = 1'b1;
            w_state_nxt       = BUSY;
            if (w_dec_div) begin
              w_cnt_nxt = CNT_W'(DIV_CYCLES - 1);
            end else begin
              w_cnt_nxt = CNT_W'(MUL_CYCLES - 1);
            end
          end else begin
            w_out_valid_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == BUSY);
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_func        <= '0;
      r_illegal     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_multi_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_func        <= w_func_nxt;
      r_illegal     <= w_illegal_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_multi_start <= w_multi_start_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign func        = r_func;
  assign illegal     = r_illegal;
  assign out_valid   = r_out_valid;
  assign multi_start = r_multi_start;
  assign busy        = r_busy;

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, handshaked successor to the combinational ALU function decoder for the MIPS datapath.
- Maps ALUOp plus the R-type funct field to an ALU function code, with a wider code space that adds shifts and SLTU.
- Sequences multi-cycle multiply/divide: issues a start pulse, holds the function code, and signals completion after a parametrised latency.
- Sits between the main control unit and the ALU/multiplier in the single-cycle CPU extended for multi-cycle ops.

Parameters:
- FUNC_W, 4, width of ALU function code (min 4).
- MUL_CYCLES, 4, cycles from multi_start to result-ready for MULT/MULTU (min 2).
- DIV_CYCLES, 8, cycles from multi_start to result-ready for DIV/DIVU (min 2).
- CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES))+1, latency counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode request valid.
- in_ready  out  1  block can accept a request this cycle.
- funct  in  6  instruction[5:0] funct field.
- alu_op  in  2  ALUOp from main control.
- func  out  FUNC_W  registered ALU function code.
- out_valid  out  1  func/illegal valid this cycle (one-cycle pulse per request).
- multi_start  out  1  one-cycle pulse launching the mult/div unit.
- busy  out  1  multi-cycle op in progress.
- illegal  out  1  qualified by out_valid; R-type funct not recognised.

Behaviour:
- Reset (async, rst=1): state=IDLE; func=0, out_valid=0, multi_start=0, busy=0, illegal=0, counter=0, in_ready=1 once rst deasserts.
- Decode (constants in package):
  - alu_op=00 R-type: 0x20→ADD(0), 0x22→SUB(1), 0x24→AND(2), 0x25→OR(3), 0x27→NOR(4), 0x2A→SLT(5), 0x00→SLL(6), 0x02→SRL(7), 0x2B→SLTU(8), 0x18/0x19→MULT(9), 0x1A/0x1B→DIV(10).
  - Any other funct → func all-ones and illegal=1.
  - alu_op=01→SUB, 10→ADD, 11→OR, regardless of funct.
- Accept: in_valid & in_ready on a rising edge.
- State IDLE:
  - in_ready=1.
  - Accepted single-cycle op: func and illegal register on that edge; out_valid=1 in the next cycle (latency 1); state stays IDLE.
  - Back-to-back single-cycle requests give out_valid high every cycle.
- Accepted MULT or DIV: func registered; multi_start=1 for exactly the next cycle; counter loaded with MUL_CYCLES-1 or DIV_CYCLES-1; state→BUSY.
- State BUSY:
  - in_ready=0; busy=1; func held stable; in_valid ignored (no accept, no queueing).
  - Counter decrements each cycle. In the cycle after the counter is seen at 0: out_valid=1, busy=0, state→IDLE, in_ready=1.
  - Total MULT accept→out_valid = MUL_CYCLES+1 cycles (DIV: DIV_CYCLES+1).
- out_valid and multi_start are single-cycle pulses; never both high for the same op.
- in_ready is combinational from state (IDLE=1, BUSY=0); no combinational path from in_valid to in_ready.
- func holds its last value when out_valid=0.
- illegal is cleared on every accept of a legal op.
- Reset mid-BUSY: immediate return to reset values; no out_valid for the aborted op.
- alu_op≠00 never triggers BUSY, even if funct=0x18.

Decomposition:
- Package alu_ctrl_pkg holds:
  - func code constants: FN_ADD..FN_DIV, FN_ILLEGAL = all-ones.
  - funct localparams: F_ADD=6'h20, etc.
  - ALUOp encodings.
  - state enum: IDLE, BUSY.
- Sub-module alu_func_decode: purely combinational funct/alu_op → {func, is_multi, is_div, illegal}. The top level owns the FSM, counter and output registers.

Test Plan:
- Reset then funct=0x22, alu_op=00, in_valid 1 cycle → next cycle out_valid=1, func=1, illegal=0, busy=0.
- Back-to-back 0x20, 0x24, 0x2A, 0x02 on consecutive cycles → out_valid high 4 consecutive cycles with func=0,2,5,7.
- funct=0x18, MUL_CYCLES=4 → multi_start pulse at cycle+1; busy=1 and in_ready=0 through the wait; in_valid with 0x20 during BUSY is ignored; out_valid with func=9 at accept+5; in_ready=1 that cycle.
- funct=0x3F, alu_op=00 → out_valid=1, illegal=1, func=15. Then alu_op=01, funct=0x3F → func=1, illegal=0.
- funct=0x1A (DIV_CYCLES=8), assert rst at accept+3 → all outputs 0 immediately; no out_valid afterwards; a fresh 0x25 request after reset yields func=3 at latency 1.
